// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter feeding a single register-file write port.
// The output stage is registered: a handshake in one cycle becomes a write in the next.
module rf_write_arbiter #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [ADDR_W-1:0] addressw,
   output logic [DATA_W-1:0] writeData,
   output logic              writeEn,
   input  logic              flush,
   output logic [15:0]       wr_count
);

   // Handshake: requester i transfers in any cycle where reqi_valid && reqi_ready.
   // Ready depends only on the valids, flush and last_grant; it never waits on anything downstream.
   logic              last_grant_q;
   logic              we_q;
   logic              we_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [15:0]       cnt_q;

   logic              hs0;
   logic              hs1;
   logic              hs;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   always_comb begin
      // last_grant_q == 1 means requester 1 won most recently, so requester 0 wins a tie.
      req0_ready = rst_n & ~flush & req0_valid & (~req1_valid | last_grant_q);
      req1_ready = rst_n & ~flush & req1_valid & (~req0_valid | ~last_grant_q);
      hs0        = req0_valid & req0_ready;
      hs1        = req1_valid & req1_ready;
      hs         = hs0 | hs1;
      sel_addr   = hs1 ? req1_addr : req0_addr;
      sel_data   = hs1 ? req1_data : req0_data;
      // Writes to x0 are accepted but never reach the register file.
      we_d       = hs & (sel_addr != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
      end else begin
         we_q <= we_d;
         if (hs) begin
            last_grant_q <= hs1;
            addr_q       <= sel_addr;
            data_q       <= sel_data;
         end
         if (we_d) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign addressw  = addr_q;
   assign writeData = data_q;
   assign writeEn   = we_q;
   assign wr_count  = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter: the driver predicts grants and
// pushes expected register-file writes; a per-cycle monitor pops and compares them.
module tb_rf_write_arbiter;
   localparam int DW = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr, addressw;
   logic [DW-1:0] req0_data, req1_data, writeData;
   logic          writeEn, flush;
   logic [15:0]   wr_count;

   always #5 clk = ~clk;

   rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .addressw(addressw), .writeData(writeData), .writeEn(writeEn),
      .flush(flush), .wr_count(wr_count)
   );

   typedef struct {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [15:0]   cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          m_last = 1;       // index of the requester granted most recently
   logic [15:0] m_cnt = 16'd0;    // number of real writes issued so far, modulo 2^16

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: one observation of the write port per cycle, just after the rising edge.
   logic [AW-1:0] h_addr = '0;
   logic [DW-1:0] h_data = '0;
   logic [15:0]   h_cnt  = '0;
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (!rst_n) begin
         h_addr = '0;
         h_data = '0;
         h_cnt  = '0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missed_write: expected write for cycle %0d, still absent at cycle %0d", e.cyc, cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("writeEn", 64'(writeEn), 64'(e.we));
            check("addressw", 64'(addressw), 64'(e.addr));
            check("writeData", writeData, e.data);
            check("wr_count", 64'(wr_count), 64'(e.cnt));
            h_addr = e.addr;
            h_data = e.data;
            h_cnt  = e.cnt;
         end else begin
            check("idle_writeEn", 64'(writeEn), 64'd0);
            check("hold_addressw", 64'(addressw), 64'(h_addr));
            check("hold_writeData", writeData, h_data);
            check("hold_wr_count", 64'(wr_count), 64'(h_cnt));
         end
      end
   end

   // Drive one cycle's inputs (caller is at a falling edge), check readies, predict the write.
   task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic fl, output logic g0, output logic g1);
      int            winner;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      flush = fl;
      #1;
      winner = -1;
      if (!fl) begin
         if (v0 && v1) winner = 1 - m_last;
         else if (v0)  winner = 0;
         else if (v1)  winner = 1;
      end
      g0 = (winner == 0);
      g1 = (winner == 1);
      check("req0_ready", 64'(req0_ready), 64'(g0));
      check("req1_ready", 64'(req1_ready), 64'(g1));
      if (winner >= 0) begin
         a = (winner == 1) ? a1 : a0;
         d = (winner == 1) ? d1 : d0;
         if (a != 0) m_cnt = m_cnt + 16'd1;
         exp_q.push_back('{cyc: cyc + 1, we: (a != 0), addr: a, data: d, cnt: m_cnt});
         m_last = winner;
      end
   endtask

   task automatic idle();
      logic g0, g1;
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, g0, g1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; flush = 1'b0;
      #1;
      check("rst_req0_ready", 64'(req0_ready), 64'd0);
      check("rst_req1_ready", 64'(req1_ready), 64'd0);
      check("rst_writeEn", 64'(writeEn), 64'd0);
      check("rst_addressw", 64'(addressw), 64'd0);
      check("rst_writeData", writeData, 64'd0);
      check("rst_wr_count", 64'(wr_count), 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      m_last = 1;
      m_cnt  = 16'd0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic          g0, g1;
      logic          v0, v1, fl;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;

      // Reset state, then a handshake on the very first edge after release.
      @(negedge clk);
      @(negedge clk);
      apply_reset();
      drive(1'b1, 6'd5, 64'hA5, 1'b0, '0, '0, 1'b0, g0, g1);
      idle();

      // Continuous contention alternates 0,1,0,1 from reset.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 6'd1, 64'h1000 + 64'(i), 1'b1, 6'd2, 64'h2000 + 64'(i), 1'b0, g0, g1);
      end
      idle();

      // Write to x0 is accepted but suppressed.
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b1, 6'd0, 64'hFF, 1'b0, g0, g1);
      idle();

      // Flush blocks the grant; the request then proceeds once flush drops.
      @(negedge clk);
      drive(1'b1, 6'd9, 64'h99, 1'b0, '0, '0, 1'b1, g0, g1);
      @(negedge clk);
      drive(1'b1, 6'd9, 64'h99, 1'b0, '0, '0, 1'b0, g0, g1);
      idle();

      // Asynchronous reset right after a write appears.
      @(negedge clk);
      drive(1'b1, 6'd7, 64'h77, 1'b0, '0, '0, 1'b0, g0, g1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_writeEn", 64'(writeEn), 64'd0);
      check("async_rst_wr_count", 64'(wr_count), 64'd0);
      check("async_rst_req0_ready", 64'(req0_ready), 64'd0);
      req0_valid = 1'b0;
      m_last = 1;
      m_cnt  = 16'd0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic; a requester that was not granted keeps its request unchanged.
      v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      g0 = 1'b0; g1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!v0 || g0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = ($urandom_range(0, 7) == 0) ? 6'd0 : AW'($urandom_range(1, 63));
            d0 = {$urandom, $urandom};
         end
         if (!v1 || g1) begin
            v1 = ($urandom_range(0, 3) != 0);
            a1 = ($urandom_range(0, 7) == 0) ? 6'd0 : AW'($urandom_range(1, 63));
            d1 = {$urandom, $urandom};
         end
         fl = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         drive(v0, a0, d0, v1, a1, d1, fl, g0, g1);
      end
      idle();

      // Counter wrap: 65535 writes reach FFFF, one more returns to 0.
      apply_reset();
      for (int i = 0; i < 65536; i++) begin
         @(negedge clk);
         drive(1'b1, AW'(1 + (i % 63)), 64'(i), 1'b0, '0, '0, 1'b0, g0, g1);
      end
      idle();
      @(negedge clk);
      check("wrap_wr_count", 64'(wr_count), 64'd0);
      idle();
      idle();

      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL leftover_writes: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
